// File: rtl/lut_layer_pkg.sv
// Shared types and default sizing for the LUT layer pipeline.
// Holds the control FSM state encoding.
package lut_layer_pkg;

  localparam int DEF_N_NEURONS = 4;
  localparam int DEF_IN_BITS   = 8;
  localparam int DEF_OUT_BITS  = 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

endpackage

// File: rtl/lut_neuron_table.sv
// One neuron's truth table.
// Single write port and an asynchronous read of the current contents.
module lut_neuron_table
  import lut_layer_pkg::*;
#(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [IN_BITS-1:0]  waddr,
  input  logic [OUT_BITS-1:0] wdata,
  input  logic [IN_BITS-1:0]  raddr,
  output logic [OUT_BITS-1:0] rdata
);

  localparam int DEPTH = 1 << IN_BITS;

  logic [OUT_BITS-1:0] mem_q [DEPTH];
  logic [OUT_BITS-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/lut_layer_pipe.sv
// Layer of independent LUT neurons with a one-stage output register.
// Tables are reloaded only after the output register has drained.
module lut_layer_pipe
  import lut_layer_pkg::*;
#(
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int IN_BITS   = DEF_IN_BITS,
  parameter int OUT_BITS  = DEF_OUT_BITS,
  localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_NEURONS*IN_BITS-1:0]  in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [N_NEURONS*OUT_BITS-1:0] out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  input  logic                          cfg_en,
  output logic                          cfg_ready,
  input  logic                          cfg_we,
  input  logic [NW-1:0]                 cfg_neuron,
  input  logic [IN_BITS-1:0]            cfg_addr,
  input  logic [OUT_BITS-1:0]           cfg_data
);

  state_e state_q, state_d;
  logic   out_valid_q, out_valid_d;
  logic [N_NEURONS*OUT_BITS-1:0] out_data_q, out_data_d;
  logic [N_NEURONS*OUT_BITS-1:0] lut_data;
  logic [31:0] nidx;
  logic        take;
  logic        wr_ok;

  assign in_ready  = rst_n && (state_q == ST_RUN)
                   && (out_ready || !out_valid_q);
  assign cfg_ready = rst_n && (state_q == ST_LOAD);
  assign take      = in_valid && in_ready;
  assign nidx      = 32'(cfg_neuron);
  assign wr_ok     = cfg_we && cfg_ready
                   && (nidx < 32'(N_NEURONS));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (cfg_en) state_d = ST_DRAIN;
      ST_DRAIN: if (!out_valid_q) state_d = ST_LOAD;
      ST_LOAD:  if (!cfg_en) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (take) begin
      out_valid_d = 1'b1;
      out_data_d  = lut_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  for (genvar k = 0; k < N_NEURONS; k++) begin : g_neuron
    lut_neuron_table #(
      .IN_BITS (IN_BITS),
      .OUT_BITS(OUT_BITS)
    ) u_tbl (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (wr_ok && (cfg_neuron == NW'(k))),
      .waddr(cfg_addr),
      .wdata(cfg_data),
      .raddr(in_data[k*IN_BITS +: IN_BITS]),
      .rdata(lut_data[k*OUT_BITS +: OUT_BITS])
    );
  end

endmodule

// File: doc/lut_layer_pipe.md
LUT_LAYER_PIPE -- requirements
Module: lut_layer_pipe

Interface
REQ-001 SHALL have parameter N_NEURONS, default 4: number of independent LUT neurons.
REQ-002 SHALL have parameter IN_BITS, default 8: address (fan-in) width per neuron.
REQ-003 SHALL have parameter OUT_BITS, default 1: output width per neuron.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, synchronous and active-low.
REQ-006 SHALL have port in_data  input  N_NEURONS*IN_BITS: neuron k's address at slice [k*IN_BITS +: IN_BITS].
REQ-007 SHALL have port in_valid  input  1: in_data valid.
REQ-008 SHALL have port in_ready  output  1: block accepts in_data this cycle.
REQ-009 SHALL have port out_data  output  N_NEURONS*OUT_BITS: neuron k's result at slice [k*OUT_BITS +: OUT_BITS].
REQ-010 SHALL have port out_valid  output  1: out_data valid.
REQ-011 SHALL have port out_ready  input  1: downstream accepts out_data.
REQ-012 SHALL have port cfg_en  input  1: request to enter table-load mode.
REQ-013 SHALL have port cfg_ready  output  1: block is in LOAD and accepts cfg writes.
REQ-014 SHALL have port cfg_we  input  1: table write strobe.
REQ-015 SHALL have port cfg_neuron  input  clog2(N_NEURONS): target neuron index.
REQ-016 SHALL have port cfg_addr  input  IN_BITS: target table entry.
REQ-017 SHALL have port cfg_data  input  OUT_BITS: value to write.

Function
REQ-018 SHALL hold one 2^IN_BITS x OUT_BITS truth table per neuron in registers.
REQ-019 SHALL implement FSM with states RUN, DRAIN, LOAD.
REQ-020 In RUN, cfg_en=1 SHALL move FSM to DRAIN next cycle; otherwise it stays in RUN.
REQ-021 DRAIN SHALL hold in_ready=0 and move to LOAD in the first cycle out_valid=0.
REQ-022 LOAD SHALL assert cfg_ready=1 and hold in_ready=0; cfg_en=0 SHALL return FSM to RUN next cycle.
REQ-023 A write SHALL occur only when cfg_we=1 and cfg_ready=1: table[cfg_neuron][cfg_addr] <= cfg_data; cfg_we outside LOAD SHALL be ignored.
REQ-024 cfg_neuron >= N_NEURONS SHALL be ignored with no table changed.
REQ-025 In RUN, in_ready SHALL equal out_ready OR NOT out_valid.
REQ-026 Transfer on in_valid AND in_ready SHALL register out_data[k] = table[k][in_data slice k] for all k, with out_valid=1 the next cycle (latency 1 cycle).
REQ-027 out_data and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-028 With out_valid=1, out_ready=1 and no new transfer, out_valid SHALL fall next cycle.
REQ-029 Simultaneous output consume and input accept SHALL sustain 1 result per cycle with no bubble.
REQ-030 A lookup SHALL use table contents from before any write in the same cycle; no write and lookup can coincide, by the FSM.
REQ-031 Changes in cfg_en during DRAIN SHALL be ignored; DRAIN always completes into LOAD.

Reset
REQ-032 rst_n=0 at a clock edge SHALL set FSM=RUN, out_valid=0, out_data=0 and every table entry to 0, aborting any pending output or load.
REQ-033 During reset, in_ready and cfg_ready SHALL read 0; after release, in_ready follows REQ-025.

Structure
REQ-034 Shared package SHALL hold the FSM state enum (RUN, DRAIN, LOAD) and the default N_NEURONS/IN_BITS/OUT_BITS constants.
REQ-035 A sub-module lut_neuron_table (one neuron's table, write port and combinational read) SHALL be instantiated N_NEURONS times via generate.

Verification
REQ-036 Reset, then in_data=0x..FF any with out_ready=1 -> out_valid after 1 cycle, out_data=0.
REQ-037 LOAD: neuron0 entries 0x20 to 0x27 = 1, exit; stream 0x20,0x1F,0x27 with out_ready=1 -> neuron0 outputs 1,0,1 on consecutive cycles, no bubbles.
REQ-038 out_ready=0 for 3 cycles with out_valid=1 -> out_data held, in_ready=0; out_ready=1 -> next input accepted same cycle.
REQ-039 cfg_en=1 while out_valid=1 and out_ready=0 -> FSM stays in DRAIN, cfg_ready=0 until output consumed, then LOAD.
REQ-040 cfg_we=1 in RUN and cfg_neuron=N_NEURONS in LOAD -> no table entry changes.
REQ-041 rst_n=0 mid-LOAD after writes -> all tables 0, FSM=RUN, out_valid=0.
